unidade_controle_mc: RTL and testbench

//  Multicycle control FSM for the 8-bit nRisc datapath; the counterpart that drives the ALU.

---
 rtl/unidade_controle_mc.sv | 167 ++++++++++++++++
 tb/tb_unidade_controle_mc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_mc.sv
// Multicycle control FSM for the 8-bit nRisc datapath: sequences fetch through writeback,
// drives the ALU selects and waits on a variable-latency memory with an optional timeout.
module unidade_controle_mc #(
  parameter int unsigned TIMEOUT_MEM = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] Opcode,
  input  logic       Zero,
  input  logic       mem_pronta,
  output logic [1:0] ULAOp,
  output logic       ULAFonteA,
  output logic [1:0] ULAFonteB,
  output logic [1:0] FontePC,
  output logic       EscrevePC,
  output logic       EscreveIR,
  output logic       EscreveReg,
  output logic       MemParaReg,
  output logic       IouD,
  output logic       LeMem,
  output logic       EscreveMem,
  output logic [3:0] estado,
  output logic       parado,
  output logic       erro_mem
);

  localparam int unsigned CNT_W = (TIMEOUT_MEM < 2) ? 1 : $clog2(TIMEOUT_MEM + 1);
  // Count value seen during the last permitted no-ack cycle.
  localparam int unsigned LIMIT = (TIMEOUT_MEM == 0) ? 0 : TIMEOUT_MEM - 1;

  typedef enum logic [3:0] {
    INICIO      = 4'd0,
    BUSCA       = 4'd1,
    DECODIFICA  = 4'd2,
    EXEC_R      = 4'd3,
    ESCRITA_R   = 4'd4,
    CALC_END    = 4'd5,
    ACESSO_LE   = 4'd6,
    ESCRITA_MEM = 4'd7,
    ACESSO_ESC  = 4'd8,
    DESVIO      = 4'd9,
    SALTO       = 4'd10,
    PARADO      = 4'd11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_erro;
  logic             w_erro_nxt;
  logic             w_wait;

  // State, wait counter and sticky error registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= INICIO;
      r_cnt   <= '0;
      r_erro  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_erro  <= w_erro_nxt;
    end
  end

  // Next-state and Moore outputs; write strobes in BUSCA/DESVIO also depend on inputs.
  always_comb begin
    w_state_nxt = r_state;
    w_erro_nxt  = r_erro;
    w_wait      = 1'b0;
    ULAOp       = 2'b00;
    ULAFonteA   = 1'b0;
    ULAFonteB   = 2'b00;
    FontePC     = 2'b00;
    EscrevePC   = 1'b0;
    EscreveIR   = 1'b0;
    EscreveReg  = 1'b0;
    MemParaReg  = 1'b0;
    IouD        = 1'b0;
    LeMem       = 1'b0;
    EscreveMem  = 1'b0;
    parado      = 1'b0;

    case (r_state)
      INICIO: w_state_nxt = BUSCA;
      BUSCA: begin
        w_wait    = 1'b1;
        LeMem     = 1'b1;
        ULAFonteB = 2'b01;
        if (mem_pronta) begin
          EscreveIR   = 1'b1;
          EscrevePC   = 1'b1;
          w_state_nxt = DECODIFICA;
        end
      end
      DECODIFICA: begin
        ULAFonteB = 2'b10;
        case (Opcode)
          3'b000, 3'b001, 3'b010: w_state_nxt = EXEC_R;
          3'b011, 3'b100:         w_state_nxt = CALC_END;
          3'b101:                 w_state_nxt = DESVIO;
          3'b110:                 w_state_nxt = SALTO;
          default:                w_state_nxt = PARADO;
        endcase
      end
      EXEC_R: begin
        ULAFonteA   = 1'b1;
        ULAOp       = Opcode[1:0];
        w_state_nxt = ESCRITA_R;
      end
      ESCRITA_R: begin
        EscreveReg  = 1'b1;
        w_state_nxt = BUSCA;
      end
      CALC_END: begin
        ULAFonteA   = 1'b1;
        ULAFonteB   = 2'b10;
        w_state_nxt = (Opcode == 3'b100) ? ACESSO_ESC :
                      (Opcode == 3'b011) ? ACESSO_LE  : BUSCA;
      end
      ACESSO_LE: begin
        w_wait = 1'b1;
        LeMem  = 1'b1;
        IouD   = 1'b1;
        if (mem_pronta) w_state_nxt = ESCRITA_MEM;
      end
      ESCRITA_MEM: begin
        EscreveReg  = 1'b1;
        MemParaReg  = 1'b1;
        w_state_nxt = BUSCA;
      end
      ACESSO_ESC: begin
        w_wait     = 1'b1;
        EscreveMem = 1'b1;
        IouD       = 1'b1;
        if (mem_pronta) w_state_nxt = BUSCA;
      end
      DESVIO: begin
        ULAFonteA   = 1'b1;
        ULAOp       = 2'b01;
        FontePC     = 2'b01;
        EscrevePC   = Zero;
        w_state_nxt = BUSCA;
      end
      SALTO: begin
        EscrevePC   = 1'b1;
        FontePC     = 2'b10;
        w_state_nxt = BUSCA;
      end
      PARADO:  parado = 1'b1;
      default: w_state_nxt = INICIO;
    endcase

    // A same-cycle ack wins over the timeout.
    if (w_wait && !mem_pronta && (TIMEOUT_MEM != 0) && (r_cnt == CNT_W'(LIMIT))) begin
      w_state_nxt = PARADO;
      w_erro_nxt  = 1'b1;
    end

    w_cnt_nxt = (w_wait && (w_state_nxt == r_state)) ? r_cnt + CNT_W'(1) : '0;
  end

  assign estado   = r_state;
  assign erro_mem = r_erro;

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Bench for unidade_controle_mc: table of per-cycle {inputs, expected outputs} plus
// hand-built sequences for timeout, halt and asynchronous reset; expectations go through a queue.
module tb_unidade_controle_mc;

  logic       clock;
  logic       reset_n;
  logic [2:0] Opcode;
  logic       Zero;
  logic       mem_pronta;
  logic [1:0] ULAOp;
  logic       ULAFonteA;
  logic [1:0] ULAFonteB;
  logic [1:0] FontePC;
  logic       EscrevePC, EscreveIR, EscreveReg, MemParaReg, IouD, LeMem, EscreveMem;
  logic [3:0] estado;
  logic       parado;
  logic       erro_mem;

  unidade_controle_mc #(.TIMEOUT_MEM(15)) dut (
    .clock(clock), .reset_n(reset_n), .Opcode(Opcode), .Zero(Zero), .mem_pronta(mem_pronta),
    .ULAOp(ULAOp), .ULAFonteA(ULAFonteA), .ULAFonteB(ULAFonteB), .FontePC(FontePC),
    .EscrevePC(EscrevePC), .EscreveIR(EscreveIR), .EscreveReg(EscreveReg),
    .MemParaReg(MemParaReg), .IouD(IouD), .LeMem(LeMem), .EscreveMem(EscreveMem),
    .estado(estado), .parado(parado), .erro_mem(erro_mem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {ULAOp, A, B, FontePC, {EscrevePC,EscreveIR,EscreveReg,MemParaReg,IouD,LeMem,EscreveMem}, estado, parado, erro}
  logic [19:0] w_obs;
  assign w_obs = {ULAOp, ULAFonteA, ULAFonteB, FontePC,
                  EscrevePC, EscreveIR, EscreveReg, MemParaReg, IouD, LeMem, EscreveMem,
                  estado, parado, erro_mem};

  typedef struct {
    logic [2:0]  op;
    logic        z;
    logic        mp;
    logic [19:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [19:0] sb[$];
  int          checks   = 0;
  int          failures = 0;

  function automatic vec_t mk(logic [2:0] op, logic z, logic mp, logic [3:0] st,
                              logic [1:0] ulaop, logic a, logic [1:0] b, logic [1:0] fpc,
                              logic [6:0] stb, logic par, logic err);
    vec_t v;
    v.op  = op;
    v.z   = z;
    v.mp  = mp;
    v.exp = {ulaop, a, b, fpc, stb, st, par, err};
    return v;
  endfunction

  function automatic vec_t r_ini(logic mp);
    return mk(3'b000, 1'b0, mp, 4'd0, 2'b00, 1'b0, 2'b00, 2'b00, 7'b0000000, 1'b0, 1'b0);
  endfunction

  function automatic vec_t r_bus(logic [2:0] op, logic mp);
    return mk(op, 1'b0, mp, 4'd1, 2'b00, 1'b0, 2'b01, 2'b00,
              mp ? 7'b1100010 : 7'b0000010, 1'b0, 1'b0);
  endfunction

  function automatic vec_t r_dec(logic [2:0] op, logic z, logic mp);
    return mk(op, z, mp, 4'd2, 2'b00, 1'b0, 2'b10, 2'b00, 7'b0000000, 1'b0, 1'b0);
  endfunction

  function automatic vec_t r_par(logic [2:0] op, logic mp, logic err);
    return mk(op, 1'b0, mp, 4'd11, 2'b00, 1'b0, 2'b00, 2'b00, 7'b0000000, 1'b1, err);
  endfunction

  task automatic compare(input string nm);
    logic [19:0] e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      checks++;
      if (w_obs !== e) begin
        failures++;
        $display("FAIL %s got=%05h want=%05h (estado got %0d)", nm, w_obs, e, estado);
      end
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle, then advance.
  task automatic step(input vec_t v, input string nm);
    Opcode     = v.op;
    Zero       = v.z;
    mem_pronta = v.mp;
    sb.push_back(v.exp);
    @(negedge clock);
    compare(nm);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    Opcode     = 3'b000;
    Zero       = 1'b0;
    mem_pronta = 1'b1;

    // R-type add / sub / slt with a fetch wait
    tbl.push_back(r_ini(1'b1));
    tbl.push_back(r_bus(3'b000, 1'b1));
    tbl.push_back(r_dec(3'b000, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 0, 0, 4'd3, 2'b00, 1, 2'b00, 2'b00, 7'b0000000, 0, 0));
    tbl.push_back(mk(3'b000, 0, 0, 4'd4, 2'b00, 0, 2'b00, 2'b00, 7'b0010000, 0, 0));
    tbl.push_back(r_bus(3'b001, 1'b0));
    tbl.push_back(r_bus(3'b001, 1'b1));
    tbl.push_back(r_dec(3'b001, 1'b0, 1'b1));
    tbl.push_back(mk(3'b001, 0, 1, 4'd3, 2'b01, 1, 2'b00, 2'b00, 7'b0000000, 0, 0));
    tbl.push_back(mk(3'b001, 0, 1, 4'd4, 2'b00, 0, 2'b00, 2'b00, 7'b0010000, 0, 0));
    tbl.push_back(r_bus(3'b010, 1'b1));
    tbl.push_back(r_dec(3'b010, 1'b0, 1'b1));
    tbl.push_back(mk(3'b010, 0, 1, 4'd3, 2'b10, 1, 2'b00, 2'b00, 7'b0000000, 0, 0));
    tbl.push_back(mk(3'b010, 0, 1, 4'd4, 2'b00, 0, 2'b00, 2'b00, 7'b0010000, 0, 0));
    // beq taken, beq not taken, jump
    tbl.push_back(r_bus(3'b101, 1'b1));
    tbl.push_back(r_dec(3'b101, 1'b1, 1'b1));
    tbl.push_back(mk(3'b101, 1, 1, 4'd9, 2'b01, 1, 2'b00, 2'b01, 7'b1000000, 0, 0));
    tbl.push_back(r_bus(3'b101, 1'b1));
    tbl.push_back(r_dec(3'b101, 1'b1, 1'b1));
    tbl.push_back(mk(3'b101, 0, 1, 4'd9, 2'b01, 1, 2'b00, 2'b01, 7'b0000000, 0, 0));
    tbl.push_back(r_bus(3'b110, 1'b1));
    tbl.push_back(r_dec(3'b110, 1'b0, 1'b1));
    tbl.push_back(mk(3'b110, 0, 1, 4'd10, 2'b00, 0, 2'b00, 2'b10, 7'b1000000, 0, 0));
    // lw with four cycles of memory wait
    tbl.push_back(r_bus(3'b011, 1'b1));
    tbl.push_back(r_dec(3'b011, 1'b0, 1'b1));
    tbl.push_back(mk(3'b011, 0, 1, 4'd5, 2'b00, 1, 2'b10, 2'b00, 7'b0000000, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(3'b011, 0, 0, 4'd6, 2'b00, 0, 2'b00, 2'b00, 7'b0000110, 0, 0));
    tbl.push_back(mk(3'b011, 0, 1, 4'd6, 2'b00, 0, 2'b00, 2'b00, 7'b0000110, 0, 0));
    tbl.push_back(mk(3'b011, 0, 1, 4'd7, 2'b00, 0, 2'b00, 2'b00, 7'b0011000, 0, 0));
    // sw, then halt
    tbl.push_back(r_bus(3'b100, 1'b1));
    tbl.push_back(r_dec(3'b100, 1'b0, 1'b1));
    tbl.push_back(mk(3'b100, 0, 1, 4'd5, 2'b00, 1, 2'b10, 2'b00, 7'b0000000, 0, 0));
    tbl.push_back(mk(3'b100, 0, 1, 4'd8, 2'b00, 0, 2'b00, 2'b00, 7'b0000101, 0, 0));
    tbl.push_back(r_bus(3'b000, 1'b1));
    tbl.push_back(r_dec(3'b111, 1'b0, 1'b1));
    tbl.push_back(r_par(3'b111, 1'b1, 1'b0));

    // Reset held for three cycles; outputs must be all zero meanwhile.
    repeat (2) @(posedge clock);
    #1;
    step(r_ini(1'b1), "reset_state");
    reset_n = 1'b1;

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Halt holds regardless of inputs.
    for (int i = 0; i < 20; i++)
      step(r_par(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0),
           $sformatf("halt_hold%0d", i));

    // Fetch timeout: 15 cycles without ack, then sticky error in PARADO.
    do_reset();
    step(r_ini(1'b0), "to_inicio");
    for (int i = 0; i < 15; i++) step(r_bus(3'b000, 1'b0), $sformatf("to_wait%0d", i));
    for (int i = 0; i < 5; i++) step(r_par(3'b000, 1'b1, 1'b1), $sformatf("to_parado%0d", i));

    // Ack on the 15th wait cycle wins; reset clears the sticky error.
    do_reset();
    step(r_ini(1'b0), "ack15_inicio");
    for (int i = 0; i < 14; i++) step(r_bus(3'b000, 1'b0), $sformatf("ack15_wait%0d", i));
    step(r_bus(3'b000, 1'b1), "ack15_ack");
    step(r_dec(3'b000, 1'b0, 1'b0), "ack15_dec");

    // Asynchronous reset in the middle of a store wait.
    do_reset();
    step(r_ini(1'b1), "ar_inicio");
    step(r_bus(3'b100, 1'b1), "ar_busca");
    step(r_dec(3'b100, 1'b0, 1'b1), "ar_dec");
    step(mk(3'b100, 0, 1, 4'd5, 2'b00, 1, 2'b10, 2'b00, 7'b0000000, 0, 0), "ar_calc");
    step(mk(3'b100, 0, 0, 4'd8, 2'b00, 0, 2'b00, 2'b00, 7'b0000101, 0, 0), "ar_esc");
    #2;
    reset_n = 1'b0;
    sb.push_back(20'h0);
    #1;
    compare("ar_async_drop");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(r_ini(1'b1), "ar_restart");
    step(r_bus(3'b000, 1'b1), "ar_refetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
